// File: rtl/fwd_result_pipe_pkg.sv
// Shared definitions for the forwarding result pipeline: select codes, default widths
// and the stage-entry layout.
package fwd_result_pipe_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [2:0] FWD_RF       = 3'b000;
    localparam logic [2:0] FWD_EX       = 3'b001;
    localparam logic [2:0] FWD_MEM_ALU  = 3'b010;
    localparam logic [2:0] FWD_MEM_LOAD = 3'b011;
    localparam logic [2:0] FWD_WB       = 3'b100;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  regwrite;
        logic                  load;
        logic [XLEN_DEF-1:0]   data;
    } stage_entry_t;

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage entry (rd, regwrite, load, data) with asynchronous clear and a
// bubble input that loads an empty entry instead of the incoming fields.
module fwd_stage_reg
    import fwd_result_pipe_pkg::*;
#(
    parameter int unsigned AW = REG_AW_DEF,
    parameter int unsigned DW = XLEN_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_bubble,
    input  logic [AW-1:0] i_rd,
    input  logic          i_regwrite,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic [AW-1:0] o_rd,
    output logic          o_regwrite,
    output logic          o_load,
    output logic [DW-1:0] o_data
);

    logic [AW-1:0] r_rd;
    logic          r_regwrite;
    logic          r_load;
    logic [DW-1:0] r_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_load     <= 1'b0;
            r_data     <= '0;
        end else if (i_bubble) begin
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_load     <= 1'b0;
            r_data     <= '0;
        end else begin
            r_rd       <= i_rd;
            r_regwrite <= i_regwrite;
            r_load     <= i_load;
            r_data     <= i_data;
        end
    end

    assign o_rd       = r_rd;
    assign o_regwrite = r_regwrite;
    assign o_load     = r_load;
    assign o_data     = r_data;

endmodule

// File: rtl/fwd_result_pipe.sv
// EX/MEM/WB result tags and data for operand forwarding, plus the operand select mux.
// Define FWD_WB_BYPASS_EN to let select code 100 forward WB data instead of rf data.
module fwd_result_pipe
    import fwd_result_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_issue_regwrite,
    input  logic              i_issue_load,
    input  logic              i_pc_en,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_ex_result,
    input  logic [XLEN-1:0]   i_mem_load_data,
    input  logic [2:0]        i_forward_a,
    input  logic [2:0]        i_forward_b,
    input  logic [XLEN-1:0]   i_rf_rs1_data,
    input  logic [XLEN-1:0]   i_rf_rs2_data,
    output logic [REG_AW-1:0] o_rd_ex,
    output logic [REG_AW-1:0] o_rd_mem,
    output logic [REG_AW-1:0] o_rd_wb,
    output logic              o_regwrite_ex,
    output logic              o_regwrite_mem,
    output logic              o_regwrite_wb,
    output logic              o_loadsel_ex,
    output logic              o_loadsel_mem,
    output logic [XLEN-1:0]   o_opa,
    output logic [XLEN-1:0]   o_opb,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_wb_rd,
    output logic [XLEN-1:0]   o_wb_data
);

    logic              w_ex_bubble;
    logic [REG_AW-1:0] w_ex_rd, w_mem_rd, w_wb_rd;
    logic              w_ex_regwrite, w_mem_regwrite, w_wb_regwrite;
    logic              w_ex_load, w_mem_load;
    logic [XLEN-1:0]   w_mem_alu, w_wb_data, w_wb_next_data;
    logic [XLEN-1:0]   w_unused_ex_data;
    logic              w_unused_wb_load;

    // flush takes priority: any redirect or stall turns the issue slot into a bubble
    assign w_ex_bubble    = !(i_pc_en && !i_flush && i_issue_valid);
    assign w_wb_next_data = w_mem_load ? i_mem_load_data : w_mem_alu;

    fwd_stage_reg #(.AW(REG_AW), .DW(XLEN)) u_ex (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_bubble   (w_ex_bubble),
        .i_rd       (i_issue_rd),
        .i_regwrite (i_issue_regwrite),
        .i_load     (i_issue_load),
        .i_data     ('0),
        .o_rd       (w_ex_rd),
        .o_regwrite (w_ex_regwrite),
        .o_load     (w_ex_load),
        .o_data     (w_unused_ex_data)
    );

    fwd_stage_reg #(.AW(REG_AW), .DW(XLEN)) u_mem (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_bubble   (1'b0),
        .i_rd       (w_ex_rd),
        .i_regwrite (w_ex_regwrite),
        .i_load     (w_ex_load),
        .i_data     (i_ex_result),
        .o_rd       (w_mem_rd),
        .o_regwrite (w_mem_regwrite),
        .o_load     (w_mem_load),
        .o_data     (w_mem_alu)
    );

    fwd_stage_reg #(.AW(REG_AW), .DW(XLEN)) u_wb (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_bubble   (1'b0),
        .i_rd       (w_mem_rd),
        .i_regwrite (w_mem_regwrite),
        .i_load     (w_mem_load),
        .i_data     (w_wb_next_data),
        .o_rd       (w_wb_rd),
        .o_regwrite (w_wb_regwrite),
        .o_load     (w_unused_wb_load),
        .o_data     (w_wb_data)
    );

    // x0 entries are kept in the stage but never advertised as writers
    assign o_rd_ex        = w_ex_rd;
    assign o_rd_mem       = w_mem_rd;
    assign o_rd_wb        = w_wb_rd;
    assign o_regwrite_ex  = w_ex_regwrite  && (w_ex_rd  != '0);
    assign o_regwrite_mem = w_mem_regwrite && (w_mem_rd != '0);
    assign o_regwrite_wb  = w_wb_regwrite  && (w_wb_rd  != '0);
    assign o_loadsel_ex   = w_ex_load;
    assign o_loadsel_mem  = w_mem_load;

    assign o_wb_en   = o_regwrite_wb;
    assign o_wb_rd   = w_wb_rd;
    assign o_wb_data = w_wb_data;

    always_comb begin
        o_opa = i_rf_rs1_data;
        case (i_forward_a)
            FWD_EX:       o_opa = i_ex_result;
            FWD_MEM_ALU:  o_opa = w_mem_alu;
            FWD_MEM_LOAD: o_opa = i_mem_load_data;
`ifdef FWD_WB_BYPASS_EN
            FWD_WB:       o_opa = w_wb_data;
`else
            FWD_WB:       o_opa = i_rf_rs1_data;
`endif
            default:      o_opa = i_rf_rs1_data;
        endcase
    end

    always_comb begin
        o_opb = i_rf_rs2_data;
        case (i_forward_b)
            FWD_EX:       o_opb = i_ex_result;
            FWD_MEM_ALU:  o_opb = w_mem_alu;
            FWD_MEM_LOAD: o_opb = i_mem_load_data;
`ifdef FWD_WB_BYPASS_EN
            FWD_WB:       o_opb = w_wb_data;
`else
            FWD_WB:       o_opb = i_rf_rs2_data;
`endif
            default:      o_opb = i_rf_rs2_data;
        endcase
    end

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: cycle-history model checked every negedge, plus literal checks.
`timescale 1ns/1ps
module tb_fwd_result_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_regwrite = 1'b0;
    logic        issue_load = 1'b0;
    logic        pc_en = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] mem_load_data = '0;
    logic [2:0]  forward_a = '0;
    logic [2:0]  forward_b = '0;
    logic [31:0] rf1 = 32'hAAAA_0001;
    logic [31:0] rf2 = 32'hBBBB_0002;

    logic [4:0]  rd_ex, rd_mem, rd_wb, wb_rd;
    logic        rw_ex, rw_mem, rw_wb, ls_ex, ls_mem, wb_en;
    logic [31:0] opa, opb, wb_data;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    fwd_result_pipe dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_issue_valid    (issue_valid),
        .i_issue_rd       (issue_rd),
        .i_issue_regwrite (issue_regwrite),
        .i_issue_load     (issue_load),
        .i_pc_en          (pc_en),
        .i_flush          (flush),
        .i_ex_result      (ex_result),
        .i_mem_load_data  (mem_load_data),
        .i_forward_a      (forward_a),
        .i_forward_b      (forward_b),
        .i_rf_rs1_data    (rf1),
        .i_rf_rs2_data    (rf2),
        .o_rd_ex          (rd_ex),
        .o_rd_mem         (rd_mem),
        .o_rd_wb          (rd_wb),
        .o_regwrite_ex    (rw_ex),
        .o_regwrite_mem   (rw_mem),
        .o_regwrite_wb    (rw_wb),
        .o_loadsel_ex     (ls_ex),
        .o_loadsel_mem    (ls_mem),
        .o_opa            (opa),
        .o_opb            (opb),
        .o_wb_en          (wb_en),
        .o_wb_rd          (wb_rd),
        .o_wb_data        (wb_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what was issued at each edge since reset, and the data inputs at that edge.
    typedef struct packed { logic [4:0] rd; logic rw; logic ld; } ins_t;
    ins_t        iss [0:4095];
    logic [31:0] exr [0:4095];
    logic [31:0] mld [0:4095];
    int          ncyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncyc = 0;
        end else begin
            if (pc_en && !flush && issue_valid)
                iss[ncyc] = '{rd: issue_rd, rw: issue_regwrite, ld: issue_load};
            else
                iss[ncyc] = '0;
            exr[ncyc] = ex_result;
            mld[ncyc] = mem_load_data;
            ncyc++;
        end
    end

    function automatic ins_t at(input int k);
        ins_t b;
        b = '0;
        if (k >= 0) b = iss[k];
        return b;
    endfunction

    function automatic logic [31:0] sel(input logic [2:0] code, input logic [31:0] rf,
                                        input logic [31:0] ex, input logic [31:0] alu,
                                        input logic [31:0] ld, input logic [31:0] wb);
        case (code)
            3'd1: return ex;
            3'd2: return alu;
            3'd3: return ld;
`ifdef FWD_WB_BYPASS_EN
            3'd4: return wb;
`endif
            default: return rf;
        endcase
    endfunction

    // After edge k: EX holds issue k, MEM issue k-1 with alu from edge k,
    // WB issue k-2 with data from edge k (load) or the ALU value captured at edge k-1.
    always @(negedge clk) begin
        int k;
        ins_t e_ex, e_mem, e_wb;
        logic [31:0] alu, wbd;
        k     = ncyc - 1;
        e_ex  = at(k);
        e_mem = at(k - 1);
        e_wb  = at(k - 2);
        alu   = (k >= 0) ? exr[k] : 32'h0;
        if (e_wb.ld)     wbd = mld[k];
        else if (k >= 1) wbd = exr[k-1];
        else             wbd = 32'h0;
        chk("rd_ex", rd_ex, e_ex.rd);
        chk("rd_mem", rd_mem, e_mem.rd);
        chk("rd_wb", rd_wb, e_wb.rd);
        chk("regwrite_ex", rw_ex, e_ex.rw && e_ex.rd != 0);
        chk("regwrite_mem", rw_mem, e_mem.rw && e_mem.rd != 0);
        chk("regwrite_wb", rw_wb, e_wb.rw && e_wb.rd != 0);
        chk("loadsel_ex", ls_ex, e_ex.ld);
        chk("loadsel_mem", ls_mem, e_mem.ld);
        chk("wb_en", wb_en, e_wb.rw && e_wb.rd != 0);
        chk("wb_rd", wb_rd, e_wb.rd);
        chk("wb_data", wb_data, wbd);
        chk("opa", opa, sel(forward_a, rf1, ex_result, alu, mem_load_data, wbd));
        chk("opb", opb, sel(forward_b, rf2, ex_result, alu, mem_load_data, wbd));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rw, input logic ld);
        issue_valid = 1'b1; issue_rd = rd; issue_regwrite = rw; issue_load = ld;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_regwrite = 1'b0; issue_load = 1'b0;
    endtask

    logic [31:0] sweep_exp [0:7];

    initial begin
        sweep_exp[0] = 32'h1; sweep_exp[1] = 32'h2; sweep_exp[2] = 32'h3;
        sweep_exp[3] = 32'h4;
`ifdef FWD_WB_BYPASS_EN
        sweep_exp[4] = 32'h5;
`else
        sweep_exp[4] = 32'h1;
`endif
        sweep_exp[5] = 32'h1; sweep_exp[6] = 32'h1; sweep_exp[7] = 32'h1;

        step(); step();
        chk("reset_wb_en", wb_en, 1'b0);
        chk("reset_opa_rf", opa, 32'hAAAA_0001);
        rst_n = 1'b1;
        step();

        // basic ALU write, rd=5
        issue(5'd5, 1'b1, 1'b0); step();
        chk("t1_rd_ex", rd_ex, 5'd5);
        chk("t1_rw_ex", rw_ex, 1'b1);
        idle(); ex_result = 32'h11; step();
        chk("t1_rd_mem", rd_mem, 5'd5);
        ex_result = 32'h99; step();
        chk("t1_wb_en", wb_en, 1'b1);
        chk("t1_wb_rd", wb_rd, 5'd5);
        chk("t1_wb_data", wb_data, 32'h11);

        // load rd=7
        issue(5'd7, 1'b1, 1'b1); step();
        idle(); step();
        mem_load_data = 32'hDEAD; forward_a = 3'b011; #1;
        chk("t2_loadsel_mem", ls_mem, 1'b1);
        chk("t2_opa_load", opa, 32'hDEAD);
        step();
        chk("t2_wb_data", wb_data, 32'hDEAD);
        chk("t2_wb_rd", wb_rd, 5'd7);
        mem_load_data = 32'h0; forward_a = 3'b000;

        // load-use stall with older rd=4 draining
        issue(5'd4, 1'b1, 1'b0); step();
        issue(5'd3, 1'b1, 1'b0); pc_en = 1'b0; ex_result = 32'h44; step();
        chk("t3_rw_ex_bubble", rw_ex, 1'b0);
        chk("t3_rd_mem_old", rd_mem, 5'd4);
        pc_en = 1'b1; idle(); ex_result = 32'h0; step();
        chk("t3_wb_rd", wb_rd, 5'd4);
        chk("t3_wb_data", wb_data, 32'h44);

        // flush with rd=9
        issue(5'd9, 1'b1, 1'b0); flush = 1'b1; step();
        chk("t4_rd_ex_flush", rd_ex, 5'd0);
        flush = 1'b0; idle(); step(); step();
        chk("t4_wb_en", wb_en, 1'b0);

        // flush and stall together
        issue(5'd10, 1'b1, 1'b0); flush = 1'b1; pc_en = 1'b0; step();
        chk("t4b_rw_ex", rw_ex, 1'b0);
        flush = 1'b0; pc_en = 1'b1; idle(); step();

        // write to x0
        issue(5'd0, 1'b1, 1'b0); step();
        chk("t5_rw_ex", rw_ex, 1'b0);
        idle(); step();
        chk("t5_rw_mem", rw_mem, 1'b0);
        step();
        chk("t5_wb_en", wb_en, 1'b0);

        // forward_b sweep: WB data 5, MEM alu 3
        issue(5'd1, 1'b1, 1'b0); step();
        issue(5'd2, 1'b1, 1'b0); ex_result = 32'h5; step();
        idle(); ex_result = 32'h3; step();
        ex_result = 32'h2; mem_load_data = 32'h4; rf2 = 32'h1;
        for (int c = 0; c < 8; c++) begin
            forward_b = 3'(c); #1;
            chk($sformatf("t6_opb_code%0d", c), opb, sweep_exp[c]);
        end
        forward_b = 3'b000; step();

        // mixed traffic, checked by the model
        for (int i = 0; i < 24; i++) begin
            issue(5'(i), i[1], i[0]);
            pc_en = (i % 5) != 3;
            flush = (i % 7) == 4;
            ex_result = 32'h100 + 32'(i);
            mem_load_data = 32'h5000 + 32'(i * 3);
            forward_a = 3'(i);
            forward_b = 3'(7 - (i % 8));
            step();
        end
        pc_en = 1'b1; flush = 1'b0;

        // reset mid-operation drops the in-flight write immediately
        issue(5'd6, 1'b1, 1'b0); step();
        idle(); ex_result = 32'h66; step(); step();
        chk("t7_wb_en_before", wb_en, 1'b1);
        rst_n = 1'b0; #1;
        chk("t7_wb_en_reset", wb_en, 1'b0);
        chk("t7_rd_wb_reset", rd_wb, 5'd0);
        step();
        rst_n = 1'b1;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_result_pipe.md
# fwd_result_pipe

Producer side of the operand-forwarding interface. Carries destination tag, write-enable, load flag and result data for each in-flight instruction through the EX, MEM and WB stages. Drives the tag/flag signals the forwarding unit compares against, and resolves that unit's 3-bit select codes into the two ALU operands. Sits between the ID/EX issue point and the register-file write port. Bubble insertion on load stalls and on control flushes happens here.

## Interface
- Parameters:
  - XLEN, 32, data width
  - REG_AW, 5, register-address width
- Ports:
  - clock  in  1  system clock, all state on rising edge
  - reset_n  in  1  asynchronous active-low reset
  - issue_valid  in  1  ID holds a real instruction
  - issue_rd  in  REG_AW  destination register of issuing instruction
  - issue_regwrite  in  1  issuing instruction writes rd
  - issue_load  in  1  issuing instruction is a load
  - pc_en  in  1  0 = load-use stall; ID held, bubble into EX
  - flush  in  1  control redirect; bubble into EX
  - ex_result  in  XLEN  ALU result of the instruction currently in EX
  - mem_load_data  in  XLEN  data-memory read data for the instruction currently in MEM
  - forward_a, forward_b  in  3  select codes from forwarding unit
  - rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data
  - rd_ex, rd_mem, rd_wb  out  REG_AW  stage destination tags
  - regwrite_ex, regwrite_mem, regwrite_wb  out  1  stage write-enables
  - loadsel_ex, loadsel_mem  out  1  stage load flags
  - opa, opb  out  XLEN  resolved operands
  - wb_en  out  1  register-file write enable
  - wb_rd  out  REG_AW  register-file write address
  - wb_data  out  XLEN  register-file write data

## Operation
- **Three stage registers:**
  - EX: rd, regwrite, load
  - MEM: rd, regwrite, load, alu
  - WB: rd, regwrite, data
- **EX capture:** if pc_en && !flush && issue_valid, take the issue fields. Otherwise load a bubble (rd=0, regwrite=0, load=0). flush wins over pc_en.
- **MEM capture:** always takes EX fields, plus alu <= ex_result.
- **WB capture:** always takes MEM fields; data <= (MEM.load ? mem_load_data : MEM.alu).
- **Tag to x0:** a regwrite entry with rd=0 is stored as-is. Its regwrite_* output is forced 0, so x0 is never written or forwarded from.
- **Operand select (combinational)**, same mapping for opa/forward_a with rf_rs1_data and opb/forward_b with rf_rs2_data:
  - 000 → rf data
  - 001 → ex_result
  - 010 → MEM.alu
  - 011 → mem_load_data
  - 100 → WB.data
  - 101–111 → rf data
- **Writeback outputs:** wb_en = regwrite_wb, wb_rd = WB.rd, wb_data = WB.data.

## Timing
- **Reset:** all stage fields 0, so all rd_*/regwrite_*/loadsel_*/wb_* outputs are 0. opa/opb then follow rf data because no stage is valid.
- **Latency:** an instruction issued at edge N appears in EX after N, MEM after N+1, and at the wb_* outputs after N+2 (register-file write at edge N+3).
- **Stall:** pc_en=0 inserts exactly one bubble per stalled cycle. MEM and WB keep advancing, so older instructions drain.
- **Flush and stall together:** one bubble.
- **Reset mid-operation:** asynchronous clear of all stages. An in-flight write is lost; wb_en drops immediately.
- opa/opb have zero-cycle latency from forward_* and the data inputs.

## Configuration
- FWD_WB_BYPASS_EN:
  - Defined: code 100 selects WB.data.
  - Undefined: code 100 selects rf data. The register file must then be write-before-read; WB.data is still used for wb_data.

## Structure
- Shared package:
  - Forward-code constants: FWD_RF, FWD_EX, FWD_MEM_ALU, FWD_MEM_LOAD, FWD_WB
  - Stage-entry struct typedef: rd, regwrite, load, data
  - XLEN/REG_AW defaults
- One sub-module, fwd_stage_reg: parameterised stage register with async reset and a bubble input, instantiated three times.
- Operand mux is inline combinational logic.

## Test plan
- After reset: issue rd=5, regwrite=1, ex_result=0x11 → rd_ex=5/regwrite_ex=1 next cycle; rd_mem=5 the cycle after; wb_en=1, wb_rd=5, wb_data=0x11 at N+2.
- Load: issue rd=7, load=1, mem_load_data=0xDEAD in its MEM cycle → loadsel_mem=1 with forward_a=011 gives opa=0xDEAD; wb_data=0xDEAD the next cycle.
- pc_en=0 for one cycle with issue rd=3 valid → EX holds a bubble (regwrite_ex=0); the older MEM entry still reaches WB on schedule.
- flush=1 together with issue rd=9 → no rd=9 ever appears on rd_ex; wb_en stays 0 for that slot.
- Issue rd=0, regwrite=1 → regwrite_ex/mem/wb all 0; wb_en never asserted.
- forward_b sweep 000–111 with distinct values (rf=0x1, ex=0x2, mem alu=0x3, load=0x4, wb=0x5) → opb = 0x1,0x2,0x3,0x4,0x5,0x1,0x1,0x1. Code 100 gives 0x1 when FWD_WB_BYPASS_EN is undefined.
